// File: rtl/ili_init_seq.sv
// ili_init_seq: ROM-driven ILI panel bring-up (reset pulse, post-reset wait, command/data bytes, ms delays).
module ili_init_seq #(
    parameter int MS_TICKS    = 100000,
    parameter int POST_RST_MS = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_start,
    output logic       o_reset_ena,
    output logic       o_reset_val,
    input  logic       i_reset_sent,
    output logic       o_tx_valid,
    output logic [7:0] o_tx_data,
    output logic       o_tx_dc,
    input  logic       i_tx_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_init_ok
);
    localparam int TW = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(MS_TICKS - 1);
    localparam logic [7:0] POST_MS = 8'(POST_RST_MS);
    localparam logic [1:0] T_CMD = 2'd0, T_DAT = 2'd1, T_DLY = 2'd2, T_END = 2'd3;

    typedef enum logic [2:0] {IDLE, RST_LO, RST_HI, POST_WAIT, FETCH, SEND, DELAY, DONE} state_t;

    state_t        r_state, w_next;
    logic [3:0]    r_idx;
    logic [TW-1:0] r_tick;
    logic [7:0]    r_ms;
    logic          r_init_ok;
    logic [9:0]    w_entry;
    logic [7:0]    w_target;
    logic          w_waiting, w_expire, w_xfer;

    always_comb begin
        case (r_idx)
            4'd0:    w_entry = {T_CMD, 8'h01};
            4'd1:    w_entry = {T_DLY, 8'd5};
            4'd2:    w_entry = {T_CMD, 8'h11};
            4'd3:    w_entry = {T_DLY, 8'd120};
            4'd4:    w_entry = {T_CMD, 8'h3A};
            4'd5:    w_entry = {T_DAT, 8'h55};
            4'd6:    w_entry = {T_CMD, 8'h36};
            4'd7:    w_entry = {T_DAT, 8'h48};
            4'd8:    w_entry = {T_CMD, 8'h29};
            default: w_entry = {T_END, 8'h00};
        endcase
    end

    // One delay engine serves both the post-reset wait and ROM delays; target 0 expires at once.
    assign w_waiting = (r_state == POST_WAIT) || (r_state == DELAY);
    assign w_target  = (r_state == POST_WAIT) ? POST_MS : w_entry[7:0];
    assign w_expire  = w_waiting && ((w_target == 8'd0) || (r_tick == TICK_MAX && r_ms == w_target - 8'd1));
    assign w_xfer    = (r_state == SEND) && i_tx_ready;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:      w_next = i_start ? RST_LO : IDLE;
            RST_LO:    w_next = i_reset_sent ? RST_HI : RST_LO;
            RST_HI:    w_next = i_reset_sent ? POST_WAIT : RST_HI;
            POST_WAIT: w_next = w_expire ? FETCH : POST_WAIT;
            FETCH:     w_next = (w_entry[9:8] == T_DLY) ? DELAY : (w_entry[9:8] == T_END) ? DONE : SEND;
            SEND:      w_next = i_tx_ready ? FETCH : SEND;
            DELAY:     w_next = w_expire ? FETCH : DELAY;
            DONE:      w_next = IDLE;
            default:   w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_idx     <= 4'd0;
            r_tick    <= '0;
            r_ms      <= 8'd0;
            r_init_ok <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE || (r_state == POST_WAIT && w_expire))
                r_idx <= 4'd0;
            else if (w_xfer || (r_state == DELAY && w_expire))
                r_idx <= r_idx + 4'd1;
            if (w_waiting && !w_expire) begin
                r_tick <= (r_tick == TICK_MAX) ? '0 : r_tick + 1'b1;
                r_ms   <= (r_tick == TICK_MAX) ? r_ms + 8'd1 : r_ms;
            end else begin
                r_tick <= '0;
                r_ms   <= 8'd0;
            end
            if (r_state == IDLE && i_start)
                r_init_ok <= 1'b0;
            else if (r_state == FETCH && w_entry[9:8] == T_END)
                r_init_ok <= 1'b1;
        end
    end

    assign o_reset_ena = (r_state == RST_LO) || (r_state == RST_HI);
    assign o_reset_val = (r_state != RST_LO);
    assign o_tx_valid  = (r_state == SEND);
    assign o_tx_data   = (r_state == SEND) ? w_entry[7:0] : 8'h00;
    assign o_tx_dc     = (r_state == SEND) && w_entry[8];
    assign o_busy      = (r_state != IDLE);
    assign o_done      = (r_state == DONE);
    assign o_init_ok   = r_init_ok;
endmodule

// File: tb/tb_ili_init_seq.sv
// tb_ili_init_seq: scoreboard bench for ili_init_seq with reactive reset-controller and SPI models.
module tb_ili_init_seq;
    logic       clk = 1'b0, rst = 1'b1, i_start = 1'b0, i_tx_ready = 1'b1;
    logic       r_ack = 1'b0, r_stray = 1'b0, i_reset_sent;
    logic       o_reset_ena, o_reset_val, o_tx_valid, o_tx_dc, o_busy, o_done, o_init_ok;
    logic [7:0] o_tx_data;

    assign i_reset_sent = r_ack | r_stray;

    ili_init_seq #(.MS_TICKS(4), .POST_RST_MS(2)) dut (
        .clk(clk), .rst(rst), .i_start(i_start),
        .o_reset_ena(o_reset_ena), .o_reset_val(o_reset_val), .i_reset_sent(i_reset_sent),
        .o_tx_valid(o_tx_valid), .o_tx_data(o_tx_data), .o_tx_dc(o_tx_dc), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done), .o_init_ok(o_init_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic       dc;
        int         gap;
    } rec_t;

    rec_t       tbl[7];
    rec_t       q[$];
    int         errors = 0, checks = 0, cyc = 0, last_xfer = 0, done_cnt = 0, ack_cnt = 0, bp_cnt = 0;
    bit         bp_en = 1'b0, hold = 1'b0;
    logic       exp_rv = 1'b0, hold_dc = 1'b0;
    logic [7:0] hold_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Models drive inputs for the coming cycle first, then the scoreboard inspects that same cycle.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            r_ack = 1'b0; ack_cnt = 0; i_tx_ready = 1'b1; hold = 1'b0;
        end else begin
            if (o_reset_ena) begin
                ack_cnt++;
                r_ack = (ack_cnt == 3);
                if (ack_cnt == 3) ack_cnt = 0;
            end else begin
                r_ack = 1'b0; ack_cnt = 0;
            end
            i_tx_ready = !(bp_en && o_tx_valid && o_tx_data == 8'h55 && bp_cnt < 5);
            if (!i_tx_ready) bp_cnt++;
            if (hold) begin
                chk("bp_valid", {31'd0, o_tx_valid}, 1);
                chk("bp_data", {24'd0, o_tx_data}, {24'd0, hold_data});
                chk("bp_dc", {31'd0, o_tx_dc}, {31'd0, hold_dc});
            end
            hold = o_tx_valid && !i_tx_ready; hold_data = o_tx_data; hold_dc = o_tx_dc;
            if ((r_ack || r_stray) && o_reset_ena) begin
                chk("rst_level", {31'd0, o_reset_val}, {31'd0, exp_rv});
                if (o_reset_val) last_xfer = cyc;
                exp_rv = ~exp_rv;
            end
            if (o_tx_valid && i_tx_ready) begin
                if (q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_byte: got %0h expected no byte", o_tx_data);
                end else begin
                    rec_t r;
                    r = q.pop_front();
                    chk("byte_data", {24'd0, o_tx_data}, {24'd0, r.data});
                    chk("byte_dc", {31'd0, o_tx_dc}, {31'd0, r.dc});
                    chk("byte_gap", cyc - last_xfer, r.gap);
                end
                last_xfer = cyc;
            end
            if (o_done) begin
                done_cnt++;
                chk("done_gap", cyc - last_xfer, 2);
                chk("done_init_ok", {31'd0, o_init_ok}, 1);
            end
        end
    end

    task automatic push_exp(input bit bp);
        q.delete();
        foreach (tbl[i]) begin
            rec_t r;
            r = tbl[i];
            if (bp && r.data == 8'h55) r.gap += 5;
            q.push_back(r);
        end
        exp_rv = 1'b0; done_cnt = 0; bp_en = bp; bp_cnt = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk) i_start = 1'b1;
        @(negedge clk) i_start = 1'b0;
        chk("start_busy", {31'd0, o_busy}, 1);
        chk("start_init_ok_clear", {31'd0, o_init_ok}, 0);
    endtask

    task automatic run_seq(input bit bp, input bit busy_start, input bit stray);
        push_exp(bp);
        pulse_start();
        for (int k = 0; k < 2000 && done_cnt == 0; k++) begin
            @(negedge clk);
            i_start = busy_start && k == 200;
            r_stray = stray && k == 300;
            if (stray && k == 301) begin
                chk("stray_dly_busy", {31'd0, o_busy}, 1);
                chk("stray_dly_ena", {31'd0, o_reset_ena}, 0);
                chk("stray_dly_valid", {31'd0, o_tx_valid}, 0);
            end
        end
        chk("done_seen", done_cnt, 1);
        repeat (3) @(negedge clk);
        chk("done_once", done_cnt, 1);
        chk("end_busy", {31'd0, o_busy}, 0);
        chk("end_init_ok", {31'd0, o_init_ok}, 1);
        chk("bytes_left", q.size(), 0);
        chk("bp_cycles", bp_cnt, bp ? 5 : 0);
    endtask

    initial begin
        tbl[0] = '{8'h01, 1'b0, 10};
        tbl[1] = '{8'h11, 1'b0, 23};
        tbl[2] = '{8'h3A, 1'b0, 483};
        tbl[3] = '{8'h55, 1'b1, 2};
        tbl[4] = '{8'h36, 1'b0, 2};
        tbl[5] = '{8'h48, 1'b1, 2};
        tbl[6] = '{8'h29, 1'b0, 2};
        #3;
        chk("rst_ena", {31'd0, o_reset_ena}, 0);
        chk("rst_val", {31'd0, o_reset_val}, 1);
        chk("rst_valid", {31'd0, o_tx_valid}, 0);
        chk("rst_data", {24'd0, o_tx_data}, 0);
        chk("rst_dc", {31'd0, o_tx_dc}, 0);
        chk("rst_busy", {31'd0, o_busy}, 0);
        chk("rst_done", {31'd0, o_done}, 0);
        chk("rst_init_ok", {31'd0, o_init_ok}, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_after_rst", {31'd0, o_busy}, 0);
        r_stray = 1'b1;
        @(negedge clk) r_stray = 1'b0;
        chk("stray_idle_busy", {31'd0, o_busy}, 0);
        chk("stray_idle_ena", {31'd0, o_reset_ena}, 0);
        chk("stray_idle_valid", {31'd0, o_tx_valid}, 0);
        run_seq(1'b0, 1'b0, 1'b0);
        run_seq(1'b1, 1'b1, 1'b1);
        push_exp(1'b0);
        pulse_start();
        for (int k = 0; k < 1000 && !(o_tx_valid && o_tx_data == 8'h3A); k++) @(negedge clk);
        chk("reached_3a", {24'd0, o_tx_data}, 8'h3A);
        #1 rst = 1'b1;
        #1;
        chk("abort_valid", {31'd0, o_tx_valid}, 0);
        chk("abort_data", {24'd0, o_tx_data}, 0);
        chk("abort_busy", {31'd0, o_busy}, 0);
        chk("abort_init_ok", {31'd0, o_init_ok}, 0);
        chk("abort_ena", {31'd0, o_reset_ena}, 0);
        q.delete();
        @(negedge clk) rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_stays_idle", {31'd0, o_busy}, 0);
        run_seq(1'b0, 1'b0, 1'b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
